alu_issue: RTL and testbench

- Upstream issue/writeback stage for the 4-bit ALU (`alu_4bit`).
- Accepts operation commands over a valid/ready handshake and reads operands from a small internal register file, or takes an immediate.
- Drives the combinational ALU, writes the result back to the register file, and presents result plus flags on an output valid/ready handshake.
- Forms the core of the NVBoard calculator datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_issue.sv | 149 ++++++++++++++
 tb/tb_alu_issue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the calculator ALU datapath: function codes,
// issue-stage FSM encoding and result flag bit positions.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_LT  = 3'b110;
   localparam logic [2:0] ALU_EQ  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_CARRY = 2;
   localparam int NFLAGS     = 3;

endpackage

// File: rtl/alu_regfile.sv
// Small operand register file: two asynchronous read ports, one synchronous
// write port, every entry reset asynchronously to RESET_VAL.
module alu_regfile #(
   parameter int                WIDTH     = 4,
   parameter int                NREGS     = 4,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(NREGS)-1:0] rd_addr_a,
   input  logic [$clog2(NREGS)-1:0] rd_addr_b,
   output logic [WIDTH-1:0]         rd_data_a,
   output logic [WIDTH-1:0]         rd_data_b,
   input  logic                     wr_en,
   input  logic [$clog2(NREGS)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data
);

   logic [WIDTH-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the combinational 4-bit ALU.
// Optional sticky carry/overflow flags: define ALU_ISSUE_STICKY_FLAGS_EN.
module alu_issue
   import alu_pkg::*;
#(
   parameter int                WIDTH     = 4,
   parameter int                NREGS     = 4,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_op,
   input  logic                     cmd_imm_sel,
   input  logic [WIDTH-1:0]         cmd_imm,
   input  logic [$clog2(NREGS)-1:0] cmd_rs1,
   input  logic [$clog2(NREGS)-1:0] cmd_rs2,
   input  logic [$clog2(NREGS)-1:0] cmd_rd,
   output logic [2:0]               alu_fnselec,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   input  logic [WIDTH-1:0]         alu_res,
   input  logic                     alu_zero,
   input  logic                     alu_overflow,
   input  logic                     alu_carry,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic [NFLAGS-1:0]        res_flags
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
   ,
   output logic [1:0]               sticky_flags,
   input  logic                     sticky_clr
`endif
);

   localparam int AW = $clog2(NREGS);

   state_t           state;
   state_t           state_next;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [AW-1:0]    rd_q;
   logic [WIDTH-1:0] rf_a;
   logic [WIDTH-1:0] rf_b;
   logic             accept;
   logic             in_exec;
   logic [NFLAGS-1:0] flags_now;

   alu_regfile #(
      .WIDTH     (WIDTH),
      .NREGS     (NREGS),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (cmd_rs1),
      .rd_addr_b (cmd_rs2),
      .rd_data_a (rf_a),
      .rd_data_b (rf_b),
      .wr_en     (in_exec),
      .wr_addr   (rd_q),
      .wr_data   (alu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (cmd_valid) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: if (res_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      in_exec   = 1'b0;
      case (state)
         ST_IDLE: cmd_ready = 1'b1;
         ST_EXEC: in_exec   = 1'b1;
         ST_RESP: res_valid = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   assign accept = cmd_valid && cmd_ready;

   // Operands are captured at accept so the ALU inputs stay frozen through EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         rd_q <= '0;
      end else if (accept) begin
         op_q <= cmd_op;
         a_q  <= rf_a;
         b_q  <= cmd_imm_sel ? cmd_imm : rf_b;
         rd_q <= cmd_rd;
      end
   end

   assign alu_fnselec = op_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;

   always_comb begin
      flags_now             = '0;
      flags_now[FLAG_ZERO]  = alu_zero;
      flags_now[FLAG_OVF]   = alu_overflow;
      flags_now[FLAG_CARRY] = alu_carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data  <= '0;
         res_flags <= '0;
      end else if (in_exec) begin
         res_data  <= alu_res;
         res_flags <= flags_now;
      end
   end

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
   // A clear coinciding with a capture wipes the old flags but keeps the new ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_flags <= '0;
      end else if (in_exec) begin
         sticky_flags <= (sticky_clr ? 2'b00 : sticky_flags) | {alu_carry, alu_overflow};
      end else if (sticky_clr) begin
         sticky_flags <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU and register model.
// Sticky-flag scenarios are built only when ALU_ISSUE_STICKY_FLAGS_EN is defined.
module tb_alu_issue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic       cmd_imm_sel;
   logic [3:0] cmd_imm;
   logic [1:0] cmd_rs1;
   logic [1:0] cmd_rs2;
   logic [1:0] cmd_rd;
   logic [2:0] alu_fnselec;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_res;
   logic       alu_zero;
   logic       alu_overflow;
   logic       alu_carry;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic [2:0] res_flags;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
   logic [1:0] sticky_flags;
   logic       sticky_clr;
`endif

   int         checks = 0;
   int         errors = 0;
   logic [3:0] mregs [4];
   logic [1:0] msticky;
   logic [3:0] obs_res;
   logic [2:0] obs_flags;

   alu_issue dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_imm_sel  (cmd_imm_sel),
      .cmd_imm      (cmd_imm),
      .cmd_rs1      (cmd_rs1),
      .cmd_rs2      (cmd_rs2),
      .cmd_rd       (cmd_rd),
      .alu_fnselec  (alu_fnselec),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_res      (alu_res),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .alu_carry    (alu_carry),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_flags    (res_flags)
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
      ,
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr)
`endif
   );

   always #5 clk = ~clk;

   // Arithmetic done on plain integers; returns {carry, overflow, zero, result}.
   function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int ua, ub, sa, sb, r, s;
      logic c, o;
      logic [3:0] res;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      c = 1'b0;
      o = 1'b0;
      res = 4'd0;
      case (op)
         3'd0: begin r = ua + ub; s = sa + sb; res = 4'(r % 16); c = (r > 15); o = (s > 7) || (s < -8); end
         3'd1: begin r = ua - ub; s = sa - sb; res = 4'((r + 16) % 16); c = (r < 0); o = (s > 7) || (s < -8); end
         3'd2: res = ~a;
         3'd3: res = a & b;
         3'd4: res = a | b;
         3'd5: res = a ^ b;
         3'd6: res = (ua < ub) ? 4'd1 : 4'd0;
         default: res = (ua == ub) ? 4'd1 : 4'd0;
      endcase
      return {c, o, (res == 4'd0), res};
   endfunction

   always_comb {alu_carry, alu_overflow, alu_zero, alu_res} = alu_fn(alu_fnselec, alu_a, alu_b);

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [2:0] op, input logic sel, input logic [3:0] imm,
                                 input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd);
      cmd_op      = op;
      cmd_imm_sel = sel;
      cmd_imm     = imm;
      cmd_rs1     = rs1;
      cmd_rs2     = rs2;
      cmd_rd      = rd;
   endtask

   task automatic set_clr(input logic v);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
      sticky_clr = v;
`else
      if (v) $display("[TB] sticky clear requested without sticky feature");
`endif
   endtask

   task automatic check_sticky(input string tag, input logic [1:0] exp);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
      check(tag, 8'(sticky_flags), 8'(exp));
`else
      if (exp === 2'bxx) $display("[TB] %s", tag);
`endif
   endtask

   // Full command round trip, optionally stalling in RESP and clearing sticky flags during EXEC.
   task automatic check_output(input logic [2:0] op, input logic sel, input logic [3:0] imm,
                               input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd,
                               input int stall, input bit clr_exec);
      logic [3:0] a, b;
      logic [6:0] exp;
      int n;
      n = 0;
      apply_stimulus(op, sel, imm, rs1, rs2, rd);
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 10) begin
         tick();
         n++;
      end
      check("accept_ready", 8'(cmd_ready), 8'd1);
      a = mregs[rs1];
      b = sel ? imm : mregs[rs2];
      exp = alu_fn(op, a, b);
      tick();
      cmd_valid = 1'b0;
      if (clr_exec) set_clr(1'b1);
      check("exec_res_valid", 8'(res_valid), 8'd0);
      check("exec_cmd_ready", 8'(cmd_ready), 8'd0);
      check("exec_alu_a", 8'(alu_a), 8'(a));
      check("exec_alu_b", 8'(alu_b), 8'(b));
      check("exec_alu_fn", 8'(alu_fnselec), 8'(op));
      tick();
      set_clr(1'b0);
      mregs[rd] = exp[3:0];
      msticky = (clr_exec ? 2'b00 : msticky) | exp[6:5];
      obs_res = res_data;
      obs_flags = res_flags;
      check("resp_valid", 8'(res_valid), 8'd1);
      check("resp_data", 8'(res_data), 8'(exp[3:0]));
      check("resp_flags", 8'(res_flags), 8'(exp[6:4]));
      check_sticky("resp_sticky", msticky);
      if (stall > 0) begin
         res_ready = 1'b0;
         apply_stimulus(3'($urandom_range(0, 7)), 1'b1, 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
         cmd_valid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 8'(res_valid), 8'd1);
            check("stall_data", 8'(res_data), 8'(exp[3:0]));
            check("stall_cmd_ready", 8'(cmd_ready), 8'd0);
         end
         cmd_valid = 1'b0;
         res_ready = 1'b1;
      end
      tick();
      check("idle_valid", 8'(res_valid), 8'd0);
      check("idle_cmd_ready", 8'(cmd_ready), 8'd1);
   endtask

   initial begin
      logic [3:0] q[$];
      logic [3:0] e;
      logic [6:0] r;
      int accepts, last_acc;
      bit acc_flag;

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      apply_stimulus(3'd0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0);
      set_clr(1'b0);
      for (int i = 0; i < 4; i++) mregs[i] = 4'd0;
      msticky = 2'b00;
      tick();
      tick();
      check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
      check("rst_res_valid", 8'(res_valid), 8'd0);
      check("rst_res_data", 8'(res_data), 8'd0);
      check("rst_res_flags", 8'(res_flags), 8'd0);
      check("rst_alu_fn", 8'(alu_fnselec), 8'd0);
      check("rst_alu_a", 8'(alu_a), 8'd0);
      check("rst_alu_b", 8'(alu_b), 8'd0);
      check_sticky("rst_sticky", 2'b00);
      rst_n = 1'b1;
      tick();

      $display("[TB] directed add and read-after-write");
      check_output(3'd0, 1'b1, 4'h5, 2'd0, 2'd0, 2'd1, 0, 1'b0);
      check("r1_is_5", 8'(obs_res), 8'h5);
      check_output(3'd0, 1'b1, 4'h9, 2'd0, 2'd0, 2'd2, 0, 1'b0);
      check_output(3'd0, 1'b0, 4'h0, 2'd1, 2'd2, 2'd3, 0, 1'b0);
      check("add_r1_r2", 8'(obs_res), 8'hE);
      check("add_r1_r2_flags", 8'(obs_flags), 8'h0);
      check_output(3'd0, 1'b1, 4'hF, 2'd3, 2'd0, 2'd3, 0, 1'b0);
      check("add_imm_f", 8'(obs_res), 8'hD);
      check("add_imm_f_carry", 8'(obs_flags[2]), 8'd1);
      check_output(3'd0, 1'b0, 4'h0, 2'd3, 2'd3, 2'd0, 0, 1'b0);
      check("raw_r3_d", 8'(obs_res), 8'hA);

      $display("[TB] response stall");
      check_output(3'd5, 1'b0, 4'h0, 2'd1, 2'd2, 2'd1, 5, 1'b0);
      check("stall_xor", 8'(obs_res), 8'hC);

      $display("[TB] random commands");
      for (int i = 0; i < 16; i++) begin
         check_output(3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                      2'($urandom), (i % 5 == 0) ? 2 : 0, 1'b0);
      end
      check_output(3'd7, 1'b0, 4'h0, 2'd2, 2'd2, 2'd2, 0, 1'b0);
      check("eq_self", 8'(obs_res), 8'h1);

      $display("[TB] reset during EXEC");
      check_output(3'd0, 1'b1, 4'h5, 2'd0, 2'd0, 2'd1, 0, 1'b0);
      apply_stimulus(3'd0, 1'b1, 4'h1, 2'd1, 2'd0, 2'd1);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("pre_rst_exec", 8'(cmd_ready), 8'd0);
      rst_n = 1'b0;
      #1;
      check("rst_exec_valid", 8'(res_valid), 8'd0);
      check("rst_exec_ready", 8'(cmd_ready), 8'd1);
      check("rst_exec_alu_a", 8'(alu_a), 8'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) mregs[i] = 4'd0;
      msticky = 2'b00;
      tick();
      check("post_rst_ready", 8'(cmd_ready), 8'd1);
      check_output(3'd0, 1'b1, 4'h0, 2'd1, 2'd0, 2'd2, 0, 1'b0);
      check("r1_reset", 8'(obs_res), 8'h0);

      $display("[TB] back-to-back commands");
      accepts = 0;
      last_acc = -1;
      acc_flag = 1'b0;
      res_ready = 1'b1;
      apply_stimulus(3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 100 && (accepts < 8 || q.size() > 0); cyc++) begin
         if (res_valid) begin
            if (q.size() == 0) begin
               check("b2b_spurious", 8'd1, 8'd0);
            end else begin
               e = q.pop_front();
               check("b2b_data", 8'(res_data), 8'(e));
            end
         end
         if (cmd_valid && cmd_ready) begin
            if (last_acc >= 0) check("b2b_gap", 8'(cyc - last_acc), 8'd3);
            last_acc = cyc;
            r = alu_fn(cmd_op, mregs[cmd_rs1], cmd_imm_sel ? cmd_imm : mregs[cmd_rs2]);
            q.push_back(r[3:0]);
            mregs[cmd_rd] = r[3:0];
            msticky = msticky | r[6:5];
            accepts++;
            acc_flag = 1'b1;
         end
         tick();
         if (acc_flag) begin
            acc_flag = 1'b0;
            if (accepts >= 8) cmd_valid = 1'b0;
            else apply_stimulus(3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
         end
      end
      cmd_valid = 1'b0;
      check("b2b_accepts", 8'(accepts), 8'd8);
      check("b2b_drained", 8'(q.size()), 8'd0);

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
      $display("[TB] sticky flags");
      set_clr(1'b1);
      tick();
      set_clr(1'b0);
      msticky = 2'b00;
      check_sticky("sticky_cleared0", 2'b00);
      check_output(3'd1, 1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 0, 1'b0);
      check_output(3'd0, 1'b1, 4'hF, 2'd0, 2'd0, 2'd1, 0, 1'b0);
      check_output(3'd0, 1'b1, 4'h1, 2'd1, 2'd0, 2'd2, 0, 1'b0);
      check_sticky("sticky_carry", 2'b10);
      check_output(3'd0, 1'b1, 4'h1, 2'd0, 2'd0, 2'd3, 0, 1'b0);
      check_output(3'd0, 1'b1, 4'h1, 2'd3, 2'd0, 2'd3, 0, 1'b0);
      check_sticky("sticky_persist", 2'b10);
      set_clr(1'b1);
      tick();
      set_clr(1'b0);
      msticky = 2'b00;
      check_sticky("sticky_pulse_clr", 2'b00);
      check_output(3'd0, 1'b1, 4'h7, 2'd0, 2'd0, 2'd2, 0, 1'b0);
      check_output(3'd0, 1'b1, 4'h1, 2'd2, 2'd0, 2'd2, 0, 1'b0);
      check_sticky("sticky_ovf", 2'b01);
      check_output(3'd0, 1'b1, 4'h1, 2'd1, 2'd0, 2'd3, 0, 1'b1);
      check_sticky("sticky_clr_coincident", 2'b10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
